// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: FIFO write buffer between dcache and bus, draining one write at a time; define DCACHE_WB_MERGE_EN to merge stores into the youngest entry
module dcache_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         wr_req_i,
  input  logic [2:0]   wr_type_i,
  input  logic [31:0]  wr_addr_i,
  input  logic [3:0]   wr_wstrb_i,
  input  logic [127:0] wr_data_i,
  output logic         wr_rdy_o,
  input  logic         rd_req_i,
  input  logic [31:0]  rd_addr_i,
  output logic         rd_conflict_o,
  output logic         bus_wr_req_o,
  output logic [2:0]   bus_wr_type_o,
  output logic [31:0]  bus_wr_addr_o,
  output logic [3:0]   bus_wr_wstrb_o,
  output logic [127:0] bus_wr_data_o,
  input  logic         bus_wr_rdy_i,
  input  logic         bus_wr_done_i,
  output logic         wb_empty_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  state_e state_q, state_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0] count_q, count_d;
  logic [2:0] type_q [DEPTH];
  logic [31:0] addr_q [DEPTH];
  logic [3:0] wstrb_q [DEPTH];
  logic [127:0] data_q [DEPTH];
  logic full, merge_ok, push, pop;
  assign full = count_q == (AW+1)'(DEPTH);
`ifdef DCACHE_WB_MERGE_EN
  logic [AW-1:0] last;
  logic merge;
  assign last = tail_q - 1'b1;
  assign merge_ok = count_q != '0 && wr_type_i != 3'b100 && type_q[last] == wr_type_i &&
                    addr_q[last][31:2] == wr_addr_i[31:2] && !(last == head_q && state_q != IDLE);
  assign merge = wr_req_i && merge_ok;
`else
  assign merge_ok = 1'b0;
`endif
  assign wr_rdy_o = !full || merge_ok;
  assign push = wr_req_i && !full && !merge_ok;
  assign pop = state_q == WAIT && bus_wr_done_i;
  assign bus_wr_req_o = state_q == REQ;
  assign bus_wr_type_o = type_q[head_q];
  assign bus_wr_addr_o = addr_q[head_q];
  assign bus_wr_wstrb_o = wstrb_q[head_q];
  assign bus_wr_data_o = data_q[head_q];
  assign wb_empty_o = count_q == '0 && state_q == IDLE;
  // read conflict: any live entry (including the one on the bus) holding the requested line
  always_comb begin
    rd_conflict_o = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      rd_conflict_o = rd_conflict_o | (rd_req_i && ({1'b0, AW'(i) - head_q} < count_q) &&
                      ((addr_q[i] ^ rd_addr_i) & 32'hFFFF_FFF0) == '0);
  end
  // drain sequencing and FIFO bookkeeping
  always_comb begin
    state_d = state_q == IDLE ? (count_q != '0 ? REQ : IDLE) :
              state_q == REQ ? (bus_wr_rdy_i ? WAIT : REQ) :
              (bus_wr_done_i ? IDLE : WAIT);
    head_d = head_q + AW'(pop);
    tail_d = tail_q + AW'(push);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // control registers; reset abandons any request in flight
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= IDLE;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  // entry storage: allocate at tail, or fold a matching store into the youngest entry
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        type_q[i] <= '0;
        addr_q[i] <= '0;
        wstrb_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (push) begin
      type_q[tail_q] <= wr_type_i;
      addr_q[tail_q] <= wr_addr_i;
      wstrb_q[tail_q] <= wr_wstrb_i;
      data_q[tail_q] <= wr_data_i;
    end
`ifdef DCACHE_WB_MERGE_EN
    else if (merge) begin
      wstrb_q[last] <= wstrb_q[last] | wr_wstrb_i;
      for (int b = 0; b < 4; b++)
        if (wr_wstrb_i[b]) data_q[last][8*b +: 8] <= wr_data_i[8*b +: 8];
    end
`endif
endmodule

// File: doc/dcache_write_buffer.md
# dcache_write_buffer

Write buffer between the data cache and the bus interface. Captures dirty-line writebacks and uncached stores from the dcache's write port, frees the cache immediately, and drains entries to the bus in FIFO order, one outstanding write at a time. Also flags dcache read misses that hit a pending entry, so the cache stalls the refill until that data has reached memory.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- wr_req  in  1  dcache write request.
- wr_type  in  3  000 byte, 001 half, 010 word, 100 line (128 bit).
- wr_addr  in  32  physical address.
- wr_wstrb  in  4  byte enables (non-line types).
- wr_data  in  128  line data; word types use [31:0].
- wr_rdy  out  1  buffer accepts this cycle.
- rd_req  in  1  dcache read/refill request being issued.
- rd_addr  in  32  its physical address.
- rd_conflict  out  1  rd_req hits a valid entry's line.
- bus_wr_req  out  1  write request to bus.
- bus_wr_type, bus_wr_addr, bus_wr_wstrb, bus_wr_data  out  3/32/4/128  head-entry fields.
- bus_wr_rdy  in  1  bus accepted the request.
- bus_wr_done  in  1  bus write response (completion).
- wb_empty  out  1  no valid entries and drain FSM idle.

## Operation
- Circular FIFO: head/tail pointers log2(DEPTH) bits, wrap modulo DEPTH; count 0..DEPTH (log2(DEPTH)+1 bits).
- Push: wr_req && wr_rdy stores {type, addr, wstrb, data} at tail, tail+1, count+1.
- wr_rdy = (count != DEPTH). No push when full even if a pop completes that cycle.
- Drain FSM: IDLE → REQ when count != 0; REQ holds bus_wr_req=1 with head fields stable until bus_wr_rdy → WAIT; WAIT until bus_wr_done → pop head (head+1, count−1) → IDLE.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- rd_conflict = rd_req && (any valid entry with addr[31:4] == rd_addr[31:4]), including the entry in flight. Combinational.
- wb_empty = (count==0) && FSM==IDLE.

## Timing
- Reset values: wr_rdy=1, rd_conflict=0 (given rd_req=0), bus_wr_req=0, bus_wr_* = 0, wb_empty=1; pointers/count 0; FSM IDLE.
- Push to bus_wr_req: 2 cycles minimum (edge writes entry, next edge FSM enters REQ).
- bus_wr_req is a registered state decode; fields change only on pop.
- bus_wr_done arriving in the same cycle as bus_wr_rdy is ignored; done is only sampled in WAIT.
- Reset mid-drain: all entries discarded, bus_wr_req drops asynchronously; bus must tolerate abandoned request.
- Back-to-back drains: pop cycle returns to IDLE, next REQ one cycle later (3 cycles per entry minimum with immediate rdy/done).

## Configuration
- DCACHE_WB_MERGE_EN defined: a non-line push whose addr[31:2] and wr_type match the youngest valid entry, and that entry is not the head while FSM != IDLE, is merged: per-byte replace where wr_wstrb set, wstrb ORed; no pointer/count change; merge is allowed even when full (wr_rdy=1 if merge condition holds).
- Undefined: every accepted push allocates a new entry; wr_rdy purely !full.

## Test plan
- Single line push addr 0x1000_0040, bus_wr_rdy after 1 cycle, done 2 cycles later → bus_wr_req in cycle 2, fields match, wb_empty=1 after pop.
- Push DEPTH=4 entries with bus_wr_rdy=0 → wr_rdy=0 after 4th; 5th wr_req held; after one done, push accepted next cycle, FIFO order preserved across pointer wrap.
- Entry at 0x2000_0010 pending, rd_req rd_addr 0x2000_001C → rd_conflict=1; rd_addr 0x2000_0020 → 0.
- Assert reset while in WAIT → bus_wr_req=0 immediately, count=0, wr_rdy=1, wb_empty=1.
- MERGE_EN: word store 0x3000_0004 wstrb 0011 data 0x0000_BBAA then 0x3000_0004 wstrb 1100 data 0xDDCC_0000 with bus stalled → one entry, wstrb 1111, data 0xDDCC_BBAA; without macro → two entries.
- Simultaneous push and pop at count=2 → count stays 2, next drained entry is old second entry.
